// File: rtl/cv32e40p_x_if_pkg.sv
// Shared x-interface types: the buffered writeback entry carried from the
// result channel to the register-file write port.
package cv32e40p_x_if_pkg;

  typedef struct packed {
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } x_wb_entry_t;

  // x0 results still retire but must never reach the register file
  function automatic logic entry_writes_rf(x_wb_entry_t entry);
    return entry.waddr != 5'd0;
  endfunction

endpackage

// File: rtl/cv32e40p_x_wb_fifo.sv
// In-order buffer for accepted x-interface results; empty/full are registered
// so that the ready handshake has no combinational path from valid.
module cv32e40p_x_wb_fifo
  import cv32e40p_x_if_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        push,
  input  logic        pop,
  input  x_wb_entry_t din,
  output x_wb_entry_t dout,
  output logic        empty,
  output logic        full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  x_wb_entry_t     mem [DEPTH];
  logic [AW-1:0]   wptr_reg, rptr_reg;
  logic [CW-1:0]   count_reg, count_next;
  logic            empty_reg, full_reg;

  always_comb begin
    count_next = count_reg;
    if (push && !pop) count_next = count_reg + 1'b1;
    else if (!push && pop) count_next = count_reg - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wptr_reg] <= din;
  end

  // DEPTH is a power of two, so pointer wrap is the natural overflow
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_reg  <= '0;
      rptr_reg  <= '0;
      count_reg <= '0;
      empty_reg <= 1'b1;
      full_reg  <= 1'b0;
    end else begin
      if (push) wptr_reg <= wptr_reg + 1'b1;
      if (pop)  rptr_reg <= rptr_reg + 1'b1;
      count_reg <= count_next;
      empty_reg <= (count_next == '0);
      full_reg  <= (count_next == CW'(DEPTH));
    end
  end

  assign dout  = mem[rptr_reg];
  assign empty = empty_reg;
  assign full  = full_reg;

endmodule

// File: rtl/cv32e40p_x_wb_arbiter.sv
// Shares the register-file write port between the core WB stage and buffered
// x-interface results, forcing a drain slot when results starve.
module cv32e40p_x_wb_arbiter
  import cv32e40p_x_if_pkg::*;
#(
  parameter int unsigned DEPTH        = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        core_we_i,
  input  logic [4:0]  core_waddr_i,
  input  logic [31:0] core_wdata_i,
  output logic        core_stall_o,
  input  logic        x_rvalid_i,
  output logic        x_rready_o,
  input  logic [4:0]  x_rwaddr_i,
  input  logic [31:0] x_rdata_i,
  output logic        rf_we_o,
  output logic [4:0]  rf_waddr_o,
  output logic [31:0] rf_wdata_o,
  output logic        x_wb_done_o,
  output logic [4:0]  x_wb_done_addr_o,
  output logic        buf_empty_o,
  output logic        buf_full_o
);

  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  logic [SW-1:0] starve_cnt_reg, starve_cnt_next;
  x_wb_entry_t   in_entry, head_entry, cand_entry;
  logic          buf_empty, buf_full;
  logic          in_fire, cand_valid, force_drain, core_win, x_win, push, pop;

  assign in_entry = '{waddr: x_rwaddr_i, wdata: x_rdata_i};

  cv32e40p_x_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (push),
    .pop   (pop),
    .din   (in_entry),
    .dout  (head_entry),
    .empty (buf_empty),
    .full  (buf_full)
  );

  // A reset cycle grants nobody, so a mid-drain reset never retires a result
  always_comb begin
    in_fire     = x_rvalid_i & ~buf_full;
    cand_valid  = ~rst_i & (~buf_empty | in_fire);
    cand_entry  = buf_empty ? in_entry : head_entry;
    force_drain = (starve_cnt_reg == SW'(STARVE_LIMIT)) & cand_valid;
    core_win    = ~rst_i & core_we_i & ~force_drain;
    x_win       = ~core_win & cand_valid;
    pop         = x_win & ~buf_empty;
    push        = ~rst_i & in_fire & ~(x_win & buf_empty);
  end

  always_comb begin
    starve_cnt_next = '0;
    if (cand_valid && core_win) begin
      starve_cnt_next = (starve_cnt_reg == SW'(STARVE_LIMIT)) ? starve_cnt_reg
                                                              : starve_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) starve_cnt_reg <= '0;
    else       starve_cnt_reg <= starve_cnt_next;
  end

  always_comb begin
    rf_we_o          = 1'b0;
    rf_waddr_o       = '0;
    rf_wdata_o       = '0;
    x_wb_done_o      = 1'b0;
    x_wb_done_addr_o = '0;
    if (core_win) begin
      rf_we_o    = 1'b1;
      rf_waddr_o = core_waddr_i;
      rf_wdata_o = core_wdata_i;
    end else if (x_win) begin
      rf_we_o          = entry_writes_rf(cand_entry);
      rf_waddr_o       = cand_entry.waddr;
      rf_wdata_o       = cand_entry.wdata;
      x_wb_done_o      = 1'b1;
      x_wb_done_addr_o = cand_entry.waddr;
    end
  end

  assign core_stall_o = ~rst_i & force_drain & core_we_i;
  assign x_rready_o   = ~buf_full;
  assign buf_empty_o  = buf_empty;
  assign buf_full_o   = buf_full;

endmodule

// File: tb/tb_cv32e40p_x_wb_arbiter.sv
// Randomized scoreboard bench: a queue-based model of the port-sharing rules
// predicts every cycle's outputs; a negedge monitor compares them.
module tb_cv32e40p_x_wb_arbiter;
  import cv32e40p_x_if_pkg::*;

  localparam int DEPTH        = 2;
  localparam int STARVE_LIMIT = 4;

  typedef struct packed {
    logic        stall;
    logic        rready;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        done;
    logic [4:0]  daddr;
    logic        empty;
    logic        full;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        core_we_i;
  logic [4:0]  core_waddr_i;
  logic [31:0] core_wdata_i;
  logic        core_stall_o;
  logic        x_rvalid_i;
  logic        x_rready_o;
  logic [4:0]  x_rwaddr_i;
  logic [31:0] x_rdata_i;
  logic        rf_we_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;
  logic        x_wb_done_o;
  logic [4:0]  x_wb_done_addr_o;
  logic        buf_empty_o;
  logic        buf_full_o;

  int vectors = 0;
  int miscompares = 0;

  obs_t        exp_q[$];
  x_wb_entry_t mq[$];
  int          starve = 0;
  logic [31:0] exp_rf[32];
  logic [31:0] act_rf[32];

  always #5 clk = ~clk;

  cv32e40p_x_wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk_i            (clk),
    .rst_i            (rst_i),
    .core_we_i        (core_we_i),
    .core_waddr_i     (core_waddr_i),
    .core_wdata_i     (core_wdata_i),
    .core_stall_o     (core_stall_o),
    .x_rvalid_i       (x_rvalid_i),
    .x_rready_o       (x_rready_o),
    .x_rwaddr_i       (x_rwaddr_i),
    .x_rdata_i        (x_rdata_i),
    .rf_we_o          (rf_we_o),
    .rf_waddr_o       (rf_waddr_o),
    .rf_wdata_o       (rf_wdata_o),
    .x_wb_done_o      (x_wb_done_o),
    .x_wb_done_addr_o (x_wb_done_addr_o),
    .buf_empty_o      (buf_empty_o),
    .buf_full_o       (buf_full_o)
  );

  // Drive one cycle of inputs and push the model's prediction for that cycle
  task automatic step(input logic rst, input logic cwe, input logic [4:0] caddr,
                      input logic [31:0] cdata, input logic rv, input logic [4:0] raddr,
                      input logic [31:0] rdata);
    obs_t        e;
    x_wb_entry_t in_e, cand;
    bit          full, empty, acc, have, forced;
    @(posedge clk);
    #1;
    rst_i = rst; core_we_i = cwe; core_waddr_i = caddr; core_wdata_i = cdata;
    x_rvalid_i = rv; x_rwaddr_i = raddr; x_rdata_i = rdata;

    full  = (mq.size() == DEPTH);
    empty = (mq.size() == 0);
    e = '0;
    e.rready = !full;
    e.empty  = empty;
    e.full   = full;
    if (rst) begin
      mq.delete();
      starve = 0;
    end else begin
      in_e = '{waddr: raddr, wdata: rdata};
      acc  = rv && !full;
      have = !empty || acc;
      if (empty) cand = in_e;
      else       cand = mq[0];
      forced  = (starve == STARVE_LIMIT) && have;
      e.stall = forced && cwe;
      if (cwe && !forced) begin
        e.we = 1'b1; e.waddr = caddr; e.wdata = cdata;
        exp_rf[caddr] = cdata;
        if (acc) mq.push_back(in_e);
        starve = have ? ((starve < STARVE_LIMIT) ? starve + 1 : STARVE_LIMIT) : 0;
      end else if (have) begin
        e.we = (cand.waddr != 5'd0); e.waddr = cand.waddr; e.wdata = cand.wdata;
        e.done = 1'b1; e.daddr = cand.waddr;
        if (e.we) exp_rf[cand.waddr] = cand.wdata;
        if (!empty) begin
          void'(mq.pop_front());
          if (acc) mq.push_back(in_e);
        end
        starve = 0;
      end else begin
        starve = 0;
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
  endtask

  // Keep offering a result until the model says it is accepted
  task automatic offer_hold(input logic cwe, input logic [4:0] caddr, input logic [4:0] raddr,
                            input logic [31:0] rdata);
    int n = 0;
    while (mq.size() == DEPTH && n < 20) begin
      step(0, cwe, caddr, 32'hC0DE_0000 + n, 1, raddr, rdata);
      n++;
    end
    step(0, cwe, caddr, 32'hC0DE_1000, 1, raddr, rdata);
  endtask

  always @(negedge clk) begin
    obs_t a, e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = '{stall: core_stall_o, rready: x_rready_o, we: rf_we_o, waddr: rf_waddr_o,
            wdata: rf_wdata_o, done: x_wb_done_o, daddr: x_wb_done_addr_o,
            empty: buf_empty_o, full: buf_full_o};
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL cycle_outputs t=%0t actual=%h required=%h", $time, a, e);
      end
      if (x_wb_done_o === 1'b1)
        $display("retire t=%0t x%0d data=%h rf_we=%0b", $time, x_wb_done_addr_o, rf_wdata_o, rf_we_o);
      if (rf_we_o === 1'b1) act_rf[rf_waddr_o] = rf_wdata_o;
    end
  end

  initial begin
    int busy_pct;
    rst_i = 1; core_we_i = 0; core_waddr_i = 0; core_wdata_i = 0;
    x_rvalid_i = 0; x_rwaddr_i = 0; x_rdata_i = 0;
    for (int r = 0; r < 32; r++) begin
      exp_rf[r] = '0;
      act_rf[r] = '0;
    end

    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    idle(1);

    // zero-latency bypass
    step(0, 0, 5'd0, 32'd0, 1, 5'd5, 32'hDEAD_BEEF);
    idle(1);

    // starvation: x7 buffered behind a continuously writing core
    step(0, 1, 5'd1, 32'h11, 1, 5'd7, 32'h77);
    for (int k = 0; k < 7; k++) step(0, 1, 5'd2, 32'h200 + k, 0, 5'd0, 32'd0);
    idle(1);

    // fill to full, third result held off until a forced drain
    for (int k = 0; k < 3; k++) offer_hold(1, 5'd4, 5'd8 + 5'(k), 32'd100 + k);
    for (int k = 0; k < 6; k++) step(0, 1, 5'd4, 32'h400 + k, 0, 5'd0, 32'd0);
    idle(3);

    // ordering with an x0 result, then release the port
    offer_hold(1, 5'd9, 5'd0, 32'd1);
    offer_hold(1, 5'd9, 5'd3, 32'd2);
    offer_hold(1, 5'd9, 5'd3, 32'd3);
    idle(4);
    @(negedge clk);
    #1;
    vectors++;
    if (act_rf[3] !== 32'd3) begin
      miscompares++;
      $display("FAIL x3_final actual=%h required=%h", act_rf[3], 32'd3);
    end

    // reset mid-drain
    offer_hold(1, 5'd10, 5'd11, 32'hAAAA);
    offer_hold(1, 5'd10, 5'd12, 32'hBBBB);
    step(1, 0, 0, 0, 0, 0, 0);
    idle(2);

    // simultaneous push/pop with one buffered entry
    step(0, 1, 5'd13, 32'h1313, 1, 5'd14, 32'h1414);
    step(0, 0, 5'd0, 32'd0, 1, 5'd15, 32'h1515);
    idle(3);

    for (int i = 0; i < 1500; i++) begin
      busy_pct = ((i / 150) % 2) ? 90 : 40;
      step(($urandom_range(0, 149) == 0),
           ($urandom_range(0, 99) < busy_pct),
           5'($urandom_range(0, 31)), $urandom,
           ($urandom_range(0, 99) < 50),
           5'($urandom_range(0, 7)), $urandom);
    end
    idle(8);
    @(negedge clk);
    #1;

    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
    end
    for (int r = 1; r < 32; r++) begin
      vectors++;
      if (act_rf[r] !== exp_rf[r]) begin
        miscompares++;
        $display("FAIL rf_x%0d actual=%h required=%h", r, act_rf[r], exp_rf[r]);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
